// File: rtl/sys_ctrl_monitor.sv
// sys_ctrl_monitor: board-side PC-load sequencer (stall/load/ack/resume) plus probe snapshot and LED display.
// Optional load-ack timeout with ERR state is built when SYS_LOAD_TIMEOUT_EN is defined.

module sys_ctrl_probe_lane #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)      q <= '0;
    else if (cap) q <= din;
  end
endmodule

module sys_ctrl_monitor #(
  parameter  int PC_W      = 8,
  parameter  int SEL_W     = 8,
  parameter  int NCH       = 8,
  parameter  int DATA_W    = 24,
  parameter  int STALL_CYC = 4,
  parameter  int TIMEOUT   = 255,
  localparam int LED_W     = DATA_W + 3
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              SYS_load,
  input  logic [PC_W-1:0]   SYS_pc_val,
  input  logic [SEL_W-1:0]  SYS_output_sel,
  output logic [LED_W-1:0]  SYS_leds,
  input  logic [PC_W-1:0]   core_pc_cur,
  input  logic [NCH*DATA_W-1:0] probe_bus,
  input  logic              probe_valid,
  output logic              core_stall,
  output logic              core_pc_load,
  output logic [PC_W-1:0]   core_pc_val,
  input  logic              core_pc_ack
);
  // One counter serves both the drain phase and the ack timeout.
  localparam int CNT_MAX = (STALL_CYC > TIMEOUT) ? STALL_CYC : TIMEOUT;
  localparam int CNT_RAW = $clog2(CNT_MAX + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

  typedef enum logic [2:0] {
    IDLE,
    STALL,
    LOAD,
`ifdef SYS_LOAD_TIMEOUT_EN
    ERR,
`endif
    RESUME
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               load_q;
  logic               load_edge;
  logic               error_q;

  assign load_edge = SYS_load & ~load_q;

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      load_q       <= 1'b0;
      core_stall   <= 1'b0;
      core_pc_load <= 1'b0;
      core_pc_val  <= '0;
      error_q      <= 1'b0;
    end else begin
      load_q <= SYS_load;
      case (state)
        IDLE: begin
          if (load_edge) begin
            state       <= STALL;
            cnt         <= '0;
            core_stall  <= 1'b1;
            core_pc_val <= SYS_pc_val;
            error_q     <= 1'b0;
          end
        end
        STALL: begin
          if (cnt == CNT_W'(STALL_CYC - 1)) begin
            state        <= LOAD;
            cnt          <= '0;
            core_pc_load <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LOAD: begin
          // An ack arriving on the expiry edge still completes the load.
          if (core_pc_ack) begin
            state        <= RESUME;
            core_pc_load <= 1'b0;
            core_stall   <= 1'b0;
          end
`ifdef SYS_LOAD_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state        <= ERR;
            core_pc_load <= 1'b0;
            core_stall   <= 1'b0;
            error_q      <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
`ifdef SYS_LOAD_TIMEOUT_EN
        ERR:     state <= IDLE;
`endif
        RESUME:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [NCH-1:0][DATA_W-1:0] bank;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    sys_ctrl_probe_lane #(.DATA_W(DATA_W)) u_lane (
      .clk (SYS_clk),
      .rst (SYS_reset),
      .cap (probe_valid),
      .din (probe_bus[k*DATA_W +: DATA_W]),
      .q   (bank[k])
    );
  end

  logic [DATA_W-1:0] pc_ext;
  if (PC_W >= DATA_W) begin : g_pc_trunc
    assign pc_ext = core_pc_cur[DATA_W-1:0];
  end else begin : g_pc_zext
    assign pc_ext = {{(DATA_W-PC_W){1'b0}}, core_pc_cur};
  end

  // Widened select so sel == NCH is representable even when NCH == 2**SEL_W.
  logic [SEL_W:0]    sel_x;
  logic [DATA_W-1:0] disp_data;
  logic              disp_inv;

  assign sel_x = {1'b0, SYS_output_sel};

  always_comb begin
    disp_data = '0;
    disp_inv  = 1'b0;
    if (sel_x == (SEL_W+1)'(NCH)) begin
      disp_data = pc_ext;
    end else if (sel_x > (SEL_W+1)'(NCH)) begin
      disp_inv = 1'b1;
    end else begin
      for (int k = 0; k < NCH; k++)
        if (sel_x == (SEL_W+1)'(k)) disp_data = bank[k];
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) SYS_leds <= '0;
    else           SYS_leds <= {state != IDLE, error_q, disp_inv, disp_data};
  end
endmodule

// File: tb/tb_sys_ctrl_monitor.sv
// Scoreboard bench for sys_ctrl_monitor: stimulus queues expected outputs per cycle, monitor pops and checks.
module tb_sys_ctrl_monitor;
  localparam int PC_W = 8, SEL_W = 8, NCH = 8, DATA_W = 24, LED_W = 27;

  logic                  clk = 1'b0;
  logic                  sys_reset = 1'b1;
  logic                  sys_load = 1'b0;
  logic [PC_W-1:0]       pc_val = '0;
  logic [SEL_W-1:0]      sel = '0;
  logic [LED_W-1:0]      leds;
  logic [PC_W-1:0]       pc_cur = '0;
  logic [NCH*DATA_W-1:0] probe_bus = '0;
  logic                  probe_valid = 1'b0;
  logic                  stall, pc_load, ack = 1'b0;
  logic [PC_W-1:0]       pcv;

  always #5 clk = ~clk;

  sys_ctrl_monitor #(
    .PC_W(PC_W), .SEL_W(SEL_W), .NCH(NCH), .DATA_W(DATA_W), .STALL_CYC(4)
`ifdef SYS_LOAD_TIMEOUT_EN
    , .TIMEOUT(10)
`endif
  ) dut (
    .SYS_clk(clk), .SYS_reset(sys_reset), .SYS_load(sys_load), .SYS_pc_val(pc_val),
    .SYS_output_sel(sel), .SYS_leds(leds), .core_pc_cur(pc_cur), .probe_bus(probe_bus),
    .probe_valid(probe_valid), .core_stall(stall), .core_pc_load(pc_load),
    .core_pc_val(pcv), .core_pc_ack(ack)
  );

  typedef struct {
    int              cyc;
    string           nm;
    logic            stall;
    logic            load;
    logic [7:0]      pcv;
    logic [LED_W-1:0] leds;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.cyc != cyc || stall !== e.stall || pc_load !== e.load || pcv !== e.pcv || leds !== e.leds)
        $display("FAIL %s cyc=%0d/%0d got stall=%b load=%b pcv=%h leds=%h exp stall=%b load=%b pcv=%h leds=%h",
                 e.nm, cyc, e.cyc, stall, pc_load, pcv, leds, e.stall, e.load, e.pcv, e.leds);
      else
        passed++;
    end
  end

  function automatic logic [LED_W-1:0] L(input logic b, input logic er, input logic inv, input logic [23:0] d);
    return {b, er, inv, d};
  endfunction

  task automatic ex(input int at, input string nm, input logic st, input logic ld,
                    input logic [7:0] pv, input logic [LED_W-1:0] ll);
    exp_t e;
    e.cyc = at; e.nm = nm; e.stall = st; e.load = ld; e.pcv = pv; e.leds = ll;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [LED_W-1:0] BUSY = 27'h400_0000;

  initial begin
    int n;
    // reset
    tick(); tick();
    ex(cyc, "reset", 0, 0, 8'h00, '0);
    sys_reset = 1'b0;
    tick();

    // basic load sequence
    pc_val = 8'h40; sys_load = 1'b1; n = cyc + 1;
    ex(n, "ld_stall0", 1, 0, 8'h40, '0);
    for (int k = 1; k <= 3; k++) ex(n + k, "ld_stall", 1, 0, 8'h40, BUSY);
    ex(n + 4, "ld_load", 1, 1, 8'h40, BUSY);
    ex(n + 5, "ld_load_hold", 1, 1, 8'h40, BUSY);
    ex(n + 6, "ld_ack", 0, 0, 8'h40, BUSY);
    ex(n + 7, "ld_resume", 0, 0, 8'h40, BUSY);
    ex(n + 8, "ld_idle", 0, 0, 8'h40, '0);
    tick(); sys_load = 1'b0;
    repeat (5) tick();
    ack = 1'b1; tick();
    ack = 1'b0; repeat (3) tick();

    // held load with a second edge during STALL
    pc_val = 8'h11; sys_load = 1'b1; n = cyc + 1;
    ex(n, "hold_stall0", 1, 0, 8'h11, '0);
    for (int k = 1; k <= 3; k++) ex(n + k, "hold_stall", 1, 0, 8'h11, BUSY);
    ex(n + 4, "hold_load", 1, 1, 8'h11, BUSY);
    ex(n + 5, "hold_ack", 0, 0, 8'h11, BUSY);
    ex(n + 6, "hold_resume", 0, 0, 8'h11, BUSY);
    ex(n + 7, "hold_idle", 0, 0, 8'h11, '0);
    ex(n + 12, "hold_no_reload", 0, 0, 8'h11, '0);
    ex(n + 20, "hold_no_reload_end", 0, 0, 8'h11, '0);
    tick(); pc_val = 8'h22;
    tick(); sys_load = 1'b0;
    tick(); sys_load = 1'b1;
    tick(); ack = 1'b1;
    repeat (18) tick();
    ack = 1'b0; sys_load = 1'b0;
    tick();

    // probe snapshot and display mux
    probe_bus = '0;
    probe_bus[0*24 +: 24] = 24'h123456;
    probe_bus[3*24 +: 24] = 24'hABCDEF;
    probe_bus[7*24 +: 24] = 24'hFEDCBA;
    probe_valid = 1'b1; sel = 8'd3; n = cyc + 1;
    ex(n, "probe_cap", 0, 0, 8'h11, '0);
    ex(n + 1, "probe_ch3", 0, 0, 8'h11, L(0, 0, 0, 24'hABCDEF));
    ex(n + 2, "probe_ch7", 0, 0, 8'h11, L(0, 0, 0, 24'hFEDCBA));
    ex(n + 3, "probe_ch0", 0, 0, 8'h11, L(0, 0, 0, 24'h123456));
    ex(n + 4, "sel_nch_p1", 0, 0, 8'h11, L(0, 0, 1, 24'h0));
    ex(n + 5, "sel_nch_pc", 0, 0, 8'h11, L(0, 0, 0, 24'h00005C));
    ex(n + 6, "sel_max", 0, 0, 8'h11, L(0, 0, 1, 24'h0));
    tick(); probe_valid = 1'b0; probe_bus = {NCH{24'h555555}};
    tick(); sel = 8'd7;
    tick(); sel = 8'd0;
    tick(); sel = 8'd9;
    tick(); sel = 8'd8; pc_cur = 8'h5C;
    tick(); sel = 8'd255;
    tick(); sel = 8'd0;
    tick();

    // reset while in LOAD, then a fresh load
    pc_val = 8'h77; sys_load = 1'b1; n = cyc + 1;
    ex(n, "rst_stall0", 1, 0, 8'h77, L(0, 0, 0, 24'h123456));
    for (int k = 1; k <= 3; k++) ex(n + k, "rst_stall", 1, 0, 8'h77, L(1, 0, 0, 24'h123456));
    ex(n + 4, "rst_load", 1, 1, 8'h77, L(1, 0, 0, 24'h123456));
    ex(n + 5, "rst_load_hold", 1, 1, 8'h77, L(1, 0, 0, 24'h123456));
    ex(n + 6, "rst_abort", 0, 0, 8'h00, '0);
    ex(n + 7, "rst_new_stall", 1, 0, 8'h99, '0);
    ex(n + 8, "rst_new_busy", 1, 0, 8'h99, BUSY);
    ex(n + 11, "rst_new_load", 1, 1, 8'h99, BUSY);
    ex(n + 12, "rst_new_ack", 0, 0, 8'h99, BUSY);
    ex(n + 13, "rst_new_resume", 0, 0, 8'h99, BUSY);
    ex(n + 14, "rst_new_idle", 0, 0, 8'h99, '0);
    tick(); sys_load = 1'b0;
    repeat (5) tick();
    sys_reset = 1'b1;
    tick(); sys_reset = 1'b0; sys_load = 1'b1; pc_val = 8'h99;
    tick(); sys_load = 1'b0;
    repeat (4) tick();
    ack = 1'b1;
    tick(); ack = 1'b0;
    repeat (3) tick();

`ifdef SYS_LOAD_TIMEOUT_EN
    // never ack -> ERR after 10 LOAD cycles, error sticky until next load
    pc_val = 8'hA5; sys_load = 1'b1; n = cyc + 1;
    ex(n, "to_stall0", 1, 0, 8'hA5, '0);
    ex(n + 4, "to_load", 1, 1, 8'hA5, BUSY);
    ex(n + 13, "to_load_last", 1, 1, 8'hA5, BUSY);
    ex(n + 14, "to_expire", 0, 0, 8'hA5, BUSY);
    ex(n + 15, "to_err", 0, 0, 8'hA5, L(1, 1, 0, 24'h0));
    ex(n + 20, "to_sticky", 0, 0, 8'hA5, L(0, 1, 0, 24'h0));
    ex(n + 21, "to_reload", 1, 0, 8'h3C, L(0, 1, 0, 24'h0));
    ex(n + 22, "to_err_clear", 1, 0, 8'h3C, BUSY);
    ex(n + 25, "to_reload_load", 1, 1, 8'h3C, BUSY);
    ex(n + 26, "to_reload_ack", 0, 0, 8'h3C, BUSY);
    ex(n + 28, "to_reload_idle", 0, 0, 8'h3C, '0);
    tick(); sys_load = 1'b0;
    repeat (20) tick();
    sys_load = 1'b1; pc_val = 8'h3C;
    tick(); sys_load = 1'b0;
    repeat (4) tick();
    ack = 1'b1;
    tick(); ack = 1'b0;
    repeat (3) tick();
`endif

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    #2;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
